fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction prefetch buffer sitting between the program counter/instruction memory and the IF/ID pipeline register. It owns the fetch PC, fetches one instruction per cycle into a DEPTH-entry circular queue while the memory is ready, and delivers instructions in order with a valid/ready handshake. A branch/jump redirect from ID flushes the queue and restarts fetch at the new target, decoupling fetch from decode stalls.

## Interface
- DATA_W, 32: instruction width.
- ADDR_W, 32: fetch address width.
- DEPTH, 4: queue entries. Must be a power of 2 and at least 2.
- RESET_PC, 0: fetch PC after reset.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  fetch address. Always equals the fetch PC register `fpc`.
- imem_data  in  DATA_W  instruction at imem_addr. Combinational, valid in the same cycle.
- imem_ready  in  1  memory can return imem_data this cycle.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  redirect target.
- deq_ready  in  1  consumer accepts the head entry (IF/ID write enable).
- deq_valid  out  1  head entry present.
- deq_instr  out  DATA_W  head instruction. Reads 0 (NOP) when deq_valid=0.
- deq_pc4  out  ADDR_W  address of the head instruction + 4. Reads 0 when deq_valid=0.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {instr, pc4}, plus write pointer `wp`, read pointer `rp` and `count`.
  - Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- deq_valid = (count != 0) && !redirect. This is the only combinational input-to-output path.
- Dequeue (`deq`) = deq_valid && deq_ready. On a dequeue, rp increments.
- Enqueue (`enq`) = imem_ready && !redirect && (count < DEPTH || deq).
  - A push into a full queue is allowed in the same cycle as a pop.
  - On an enqueue: entry[wp] <= {imem_data, fpc+4}, wp increments, fpc <= fpc+4.
- When enq=0 and redirect=0, fpc holds. imem_addr keeps presenting fpc; a fetch that is not enqueued has no effect.
- Count update:
  - +1 on enq only.
  - -1 on deq only.
  - Unchanged when both or neither occur.
- Redirect has priority over everything. On the next edge:
  - wp=rp=0, count=0, fpc <= redirect_pc.
  - No enqueue or dequeue happens in the redirect cycle.
- Arithmetic: fpc+4 is modulo 2^ADDR_W (wraps to 0). deq_pc4 is the stored value and is never recomputed.
- Reset (Reset=0, asynchronous): fpc=RESET_PC, wp=rp=0, count=0.
  - Resulting outputs: deq_valid=0, deq_instr=0, deq_pc4=0, imem_addr=RESET_PC, count=0.
  - Storage contents need not be cleared.
  - Reset takes effect mid-operation immediately, without waiting for a clock edge.

## Timing
- Fetch-to-deliver latency is 1 cycle. An instruction fetched at edge N is at the head at cycle N+1 if the queue was empty. There is no same-cycle bypass.
- Throughput is one instruction per cycle sustained when imem_ready=1 and deq_ready=1.
- Redirect asserted in cycle N:
  - Cycle N+1: imem_addr=redirect_pc, count=0.
  - Cycle N+2: first target instruction is valid, deq_pc4=redirect_pc+4.
- Full (count=DEPTH) without a dequeue: fpc and imem_addr freeze and no entry is overwritten.
- Empty with deq_ready=1: no pop occurs and count stays 0.
- imem_ready=0: no push and fpc holds. A pop can still occur.
- Redirect together with imem_ready=0 or deq_ready=1: redirect behaviour only.
- Reset release: the first push happens at the first edge after Reset returns high, provided imem_ready=1.

## Test plan
- Fill: after reset (RESET_PC=0), hold deq_ready=0 and imem_ready=1 for 6 cycles -> count=4, imem_addr=16 held, deq_instr=mem[0], deq_pc4=4.
- Stream: from the full state, hold deq_ready=1 for 8 cycles -> heads 0,4,8,...,28 in order (pc4 4..32), one per cycle, count stays 4.
- Redirect: with count=3, pulse redirect with redirect_pc=0x40 -> deq_valid=0 in the same cycle; next cycle count=0 and imem_addr=0x40; the cycle after, deq_valid=1 and deq_pc4=0x44.
- Memory stall: drop imem_ready for 3 cycles with deq_ready=1 and count=2 -> count falls 2,1,0 and fpc is unchanged; after imem_ready returns, pushes resume at the held fpc.
- Wrap: set redirect_pc=0xFFFFFFFC and stream -> deq_pc4 of the first entry is 0, and the next fetch address is 0. Also run 3×DEPTH pushes with pointer wrap and confirm no reordering.
- Async reset mid-stream: assert Reset=0 between edges with count=3 -> count=0, deq_valid=0 and imem_addr=RESET_PC before the next edge.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch queue bus: instruction-memory side, redirect from ID, and the
// dequeue handshake toward the IF/ID register.
//   master : the fetch queue (drives imem_addr and the deq_* outputs, count)
//   slave  : the surrounding pipeline / memory
interface fetch_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              imem_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              deq_ready;
  logic              deq_valid;
  logic [DATA_W-1:0] deq_instr;
  logic [ADDR_W-1:0] deq_pc4;
  logic [CNT_W-1:0]  count;

  modport master (
    output imem_addr, deq_valid, deq_instr, deq_pc4, count,
    input  imem_data, imem_ready, redirect, redirect_pc, deq_ready
  );

  modport slave (
    input  imem_addr, deq_valid, deq_instr, deq_pc4, count,
    output imem_data, imem_ready, redirect, redirect_pc, deq_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer. Owns the fetch PC, pushes one instruction
// per cycle into a DEPTH-entry circular queue while memory is ready, and
// delivers them in order through a valid/ready handshake. A redirect
// flushes the queue and restarts fetch at redirect_pc.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_if.master (imem_*, redirect*, deq_*, count)
module fetch_queue #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of 2 and at least 2");
  end

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc4_mem   [DEPTH];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] fpc;

  logic              valid_c;
  logic              deq_c;
  logic              enq_c;
  logic [ADDR_W-1:0] fpc_plus4_c;

  // Handshake qualification; redirect masks both push and pop.
  assign valid_c     = (cnt != '0) && !bus.redirect;
  assign deq_c       = valid_c && bus.deq_ready;
  assign enq_c       = bus.imem_ready && !bus.redirect &&
                       ((cnt < CNT_W'(DEPTH)) || deq_c);
  assign fpc_plus4_c = fpc + ADDR_W'(4);

  // Control state: fetch PC, pointers, occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc <= RESET_PC;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (bus.redirect) begin
      fpc <= bus.redirect_pc;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (enq_c) begin
        fpc <= fpc_plus4_c;
        wp  <= wp + PTR_W'(1);
      end
      if (deq_c) begin
        rp <= rp + PTR_W'(1);
      end
      if (enq_c && !deq_c) begin
        cnt <= cnt + CNT_W'(1);
      end else if (deq_c && !enq_c) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (enq_c) begin
      instr_mem[wp] <= bus.imem_data;
      pc4_mem[wp]   <= fpc_plus4_c;
    end
  end

  // Head entry reads as zero (NOP) whenever it is not valid.
  assign bus.imem_addr = fpc;
  assign bus.deq_valid = valid_c;
  assign bus.deq_instr = valid_c ? instr_mem[rp] : '0;
  assign bus.deq_pc4   = valid_c ? pc4_mem[rp]   : '0;
  assign bus.count     = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, stream, redirect, memory stall,
// address wrap, pointer wrap with mixed stalls, and async reset.
module tb_fetch_queue;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] MASK   = 32'h5A5A_0000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Memory model: instruction word derived from its address.
  assign bus.imem_data = bus.imem_addr ^ MASK;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ MASK;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [19:0] pat;
    int          m_cnt;
    logic [31:0] m_head;
    logic        pop;
    logic        push;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.imem_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.deq_ready   = 1'b0;

    // Reset state
    #12;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_valid", 32'(bus.deq_valid), 32'd0);
    chk("rst_instr", bus.deq_instr, 32'd0);
    chk("rst_pc4", bus.deq_pc4, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);

    // Fill: 6 cycles, no consumer
    rst_n = 1'b1;
    bus.imem_ready = 1'b1;
    tick();
    chk("fill_lat_count", 32'(bus.count), 32'd1);
    chk("fill_lat_pc4", bus.deq_pc4, 32'd4);
    for (int i = 0; i < 5; i++) tick();
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_addr", bus.imem_addr, 32'd16);
    chk("fill_instr", bus.deq_instr, instr_of(32'd0));
    chk("fill_pc4", bus.deq_pc4, 32'd4);
    chk("fill_valid", 32'(bus.deq_valid), 32'd1);

    // Stream from full: heads 0..28, count stays 4
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("stream_pc4", bus.deq_pc4, 32'(4 * (i + 1)));
      chk("stream_instr", bus.deq_instr, instr_of(32'(4 * i)));
      chk("stream_count", 32'(bus.count), 32'd4);
      tick();
    end
    chk("stream_end_pc4", bus.deq_pc4, 32'd36);
    chk("stream_end_addr", bus.imem_addr, 32'd48);

    // Pop only (imem stalled) to reach count=3
    bus.imem_ready = 1'b0;
    tick();
    chk("pre_redir_count", 32'(bus.count), 32'd3);
    chk("pre_redir_addr", bus.imem_addr, 32'd48);

    // Redirect to 0x40 with count=3
    bus.imem_ready  = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    #1;
    chk("redir_valid_same", 32'(bus.deq_valid), 32'd0);
    chk("redir_instr_same", bus.deq_instr, 32'd0);
    tick();
    bus.redirect  = 1'b0;
    bus.deq_ready = 1'b0;
    chk("redir_n1_count", 32'(bus.count), 32'd0);
    chk("redir_n1_addr", bus.imem_addr, 32'h40);
    chk("redir_n1_valid", 32'(bus.deq_valid), 32'd0);
    tick();
    chk("redir_n2_valid", 32'(bus.deq_valid), 32'd1);
    chk("redir_n2_pc4", bus.deq_pc4, 32'h44);
    chk("redir_n2_instr", bus.deq_instr, instr_of(32'h40));
    chk("redir_n2_addr", bus.imem_addr, 32'h44);

    // Memory stall with consumer ready from count=2
    tick();
    chk("stall_pre_count", 32'(bus.count), 32'd2);
    bus.imem_ready = 1'b0;
    bus.deq_ready  = 1'b1;
    tick();
    chk("stall1_count", 32'(bus.count), 32'd1);
    chk("stall1_addr", bus.imem_addr, 32'h48);
    tick();
    chk("stall2_count", 32'(bus.count), 32'd0);
    chk("stall2_addr", bus.imem_addr, 32'h48);
    tick();
    chk("stall3_count", 32'(bus.count), 32'd0);
    chk("stall3_addr", bus.imem_addr, 32'h48);
    chk("stall3_valid", 32'(bus.deq_valid), 32'd0);
    bus.imem_ready = 1'b1;
    tick();
    chk("resume_count", 32'(bus.count), 32'd1);
    chk("resume_pc4", bus.deq_pc4, 32'h4C);
    chk("resume_instr", bus.deq_instr, instr_of(32'h48));
    chk("resume_addr", bus.imem_addr, 32'h4C);

    // Address wrap at the top of the space
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_count0", 32'(bus.count), 32'd0);
    tick();
    chk("wrap_valid", 32'(bus.deq_valid), 32'd1);
    chk("wrap_pc4", bus.deq_pc4, 32'd0);
    chk("wrap_instr", bus.deq_instr, instr_of(32'hFFFF_FFFC));
    chk("wrap_next_addr", bus.imem_addr, 32'd0);
    tick();
    chk("wrap2_pc4", bus.deq_pc4, 32'd4);
    chk("wrap2_instr", bus.deq_instr, instr_of(32'd0));
    chk("wrap2_count", 32'(bus.count), 32'd1);

    // Pointer wrap with irregular consumer stalls; order tracked by model
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    m_cnt  = 0;
    m_head = 32'h100;
    pat    = 20'b1011_0111_0100_1101_1100;
    for (int i = 0; i < 20; i++) begin
      bus.deq_ready = pat[i];
      #1;
      if (m_cnt != 0) begin
        chk("pw_pc4", bus.deq_pc4, m_head + 32'd4);
        chk("pw_instr", bus.deq_instr, instr_of(m_head));
      end else begin
        chk("pw_empty_valid", 32'(bus.deq_valid), 32'd0);
      end
      pop  = (m_cnt != 0) && pat[i];
      push = (m_cnt < DEPTH) || pop;
      if (pop) m_head = m_head + 32'd4;
      m_cnt = m_cnt + int'(push) - int'(pop);
      tick();
      chk("pw_count", 32'(bus.count), 32'(m_cnt));
    end

    // Async reset between edges with count=3
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    bus.deq_ready   = 1'b0;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("ar_pre_count", 32'(bus.count), 32'd3);
    chk("ar_pre_addr", bus.imem_addr, 32'h20C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(bus.count), 32'd0);
    chk("ar_valid", 32'(bus.deq_valid), 32'd0);
    chk("ar_addr", bus.imem_addr, 32'd0);
    chk("ar_pc4", bus.deq_pc4, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rel_count", 32'(bus.count), 32'd1);
    chk("rel_pc4", bus.deq_pc4, 32'd4);
    chk("rel_instr", bus.deq_instr, instr_of(32'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
